// File: rtl/prbs_pkg.sv
// Shared PRBS8 definitions: polynomial x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0.
package prbs_pkg;

   localparam logic [7:0] TAP_MASK = 8'hB8;

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} chk_state_t;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
      return {x[6:0], ^(x & TAP_MASK)};
   endfunction

endpackage

// File: rtl/prbs8_checker_if.sv
// Data/status bundle between a PRBS word source (master) and the checker (slave).
interface prbs8_checker_if #(parameter int ERR_CNT_W = 16);

   logic                 in_valid;
   logic [7:0]           in_data;
   logic                 clr_cnt;
   logic                 locked;
   logic                 err_pulse;
   logic [ERR_CNT_W-1:0] bit_err_cnt;
   logic [ERR_CNT_W-1:0] word_err_cnt;

   modport master (output in_valid, in_data, clr_cnt,
                   input  locked, err_pulse, bit_err_cnt, word_err_cnt);
   modport slave  (input  in_valid, in_data, clr_cnt,
                   output locked, err_pulse, bit_err_cnt, word_err_cnt);

endinterface

// File: rtl/popcount8.sv
// Combinational population count of an 8-bit word.
module popcount8 (
   input  logic [7:0] i_data,
   output logic [3:0] o_cnt
);

   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < 8; i++) o_cnt = o_cnt + {3'b000, i_data[i]};
   end

endmodule

// File: rtl/prbs8_checker.sv
// PRBS8 checker: hunts for LOCK_COUNT consecutive successors, then free-runs its own
// prediction and counts word/bit errors until UNLOCK_ERRS consecutive misses force a re-hunt.
module prbs8_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_COUNT  = 4,
   parameter int UNLOCK_ERRS = 4,
   parameter int ERR_CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   prbs8_checker_if.slave    bus
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int UW = $clog2(UNLOCK_ERRS + 1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]           r_rst_sync;
   logic                 w_rst_n;
   chk_state_t           r_state;
   logic [7:0]           r_prev;
   logic [7:0]           r_expected;
   logic                 r_have_prev;
   logic [MW-1:0]        r_match_run;
   logic [UW-1:0]        r_miss_run;
   logic                 r_err_pulse;
   logic [ERR_CNT_W-1:0] r_bit_cnt;
   logic [ERR_CNT_W-1:0] r_word_cnt;

   logic [7:0]           w_xor;
   logic [3:0]           w_pop;
   logic                 w_hunt_hit;
   logic [MW-1:0]        w_match_nxt;
   logic [UW-1:0]        w_miss_nxt;
   logic                 w_mis;
   logic [ERR_CNT_W+3:0] w_bit_sum;
   logic [ERR_CNT_W-1:0] w_bit_sat;
   logic [ERR_CNT_W-1:0] w_word_sat;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= '0;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_xor = bus.in_data ^ r_expected;
   popcount8 u_pop (.i_data(w_xor), .o_cnt(w_pop));

   // Zero is the LFSR lock-up word, so a zero stream must never count as a match.
   assign w_hunt_hit  = r_have_prev && (bus.in_data == lfsr8_next(r_prev)) && (bus.in_data != 8'h00);
   assign w_match_nxt = w_hunt_hit ? r_match_run + 1'b1 : '0;
   assign w_miss_nxt  = r_miss_run + 1'b1;
   assign w_mis       = bus.in_valid && (r_state == LOCKED) && (bus.in_data != r_expected);

   assign w_bit_sum  = {4'b0000, r_bit_cnt} + {{ERR_CNT_W{1'b0}}, w_pop};
   assign w_bit_sat  = (w_bit_sum > {4'b0000, CNT_MAX}) ? CNT_MAX : w_bit_sum[ERR_CNT_W-1:0];
   assign w_word_sat = (r_word_cnt == CNT_MAX) ? CNT_MAX : r_word_cnt + 1'b1;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= HUNT;
         r_prev      <= '0;
         r_expected  <= '0;
         r_have_prev <= 1'b0;
         r_match_run <= '0;
         r_miss_run  <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= 1'b0;
         if (bus.in_valid) begin
            if (r_state == HUNT) begin
               r_prev      <= bus.in_data;
               r_have_prev <= 1'b1;
               if (w_match_nxt == MW'(LOCK_COUNT)) begin
                  r_state     <= LOCKED;
                  r_expected  <= lfsr8_next(bus.in_data);
                  r_miss_run  <= '0;
                  r_match_run <= '0;
               end else begin
                  r_match_run <= w_match_nxt;
               end
            end else begin
               // Prediction advances on every word so one bad word costs one error only.
               r_expected <= lfsr8_next(r_expected);
               if (w_mis) begin
                  r_err_pulse <= 1'b1;
                  if (w_miss_nxt == UW'(UNLOCK_ERRS)) begin
                     r_state     <= HUNT;
                     r_prev      <= bus.in_data;
                     r_have_prev <= 1'b1;
                     r_match_run <= '0;
                     r_miss_run  <= '0;
                  end else begin
                     r_miss_run <= w_miss_nxt;
                  end
               end else begin
                  r_miss_run <= '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
      end else if (bus.clr_cnt) begin
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
      end else if (w_mis) begin
         r_bit_cnt  <= w_bit_sat;
         r_word_cnt <= w_word_sat;
      end
   end

   assign bus.locked       = (r_state == LOCKED);
   assign bus.err_pulse    = r_err_pulse;
   assign bus.bit_err_cnt  = r_bit_cnt;
   assign bus.word_err_cnt = r_word_cnt;

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: directed words with hand-computed expected outputs.
module tb_prbs8_checker;

   localparam int W = 4;

   typedef struct {
      int    due;
      logic  l;
      logic  e;
      int    b;
      int    w;
      string n;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prbs8_checker_if #(.ERR_CNT_W(W)) bus ();

   prbs8_checker #(.LOCK_COUNT(4), .UNLOCK_ERRS(4), .ERR_CNT_W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic cmp(input string n, input logic l, input logic e, input int b, input int w);
      checks++;
      if (bus.locked !== l || bus.err_pulse !== e ||
          int'(bus.bit_err_cnt) != b || int'(bus.word_err_cnt) != w) begin
         errors++;
         $display("FAIL %s: got locked=%0b err=%0b bits=%0d words=%0d, want locked=%0b err=%0b bits=%0d words=%0d",
                  n, bus.locked, bus.err_pulse, bus.bit_err_cnt, bus.word_err_cnt, l, e, b, w);
      end
   endtask

   // Monitor: compare each expectation on the falling edge after its sampling edge.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t x;
            x = q.pop_front();
            cmp(x.n, x.l, x.e, x.b, x.w);
         end
      end
   end

   task automatic send(input logic v, input logic [7:0] d, input logic c,
                       input logic el, input logic ee, input int eb, input int ew, input string n);
      exp_t x;
      @(posedge clk); #1;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.clr_cnt  = c;
      x.due = cyc + 1; x.l = el; x.e = ee; x.b = eb; x.w = ew; x.n = n;
      q.push_back(x);
   endtask

   task automatic drain();
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.clr_cnt  = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations never checked, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic release_rst();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic do_reset();
      drain();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.clr_cnt  = 1'b0;
      #1 cmp("reset_state", 1'b0, 1'b0, 0, 0);
      release_rst();
   endtask

   // 01,02,04,08 build the run; 0x11 is the fourth successor and triggers lock.
   task automatic lock_seq(input string n);
      send(1, 8'h01, 0, 0, 0, 0, 0, n);
      send(1, 8'h02, 0, 0, 0, 0, 0, n);
      send(1, 8'h04, 0, 0, 0, 0, 0, n);
      send(1, 8'h08, 0, 0, 0, 0, 0, n);
      send(1, 8'h11, 0, 1, 0, 0, 0, n);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.clr_cnt  = 1'b0;

      // Lock and free-run
      do_reset();
      lock_seq("lock");
      send(1, 8'h23, 0, 1, 0, 0, 0, "lock_run");
      send(1, 8'h47, 0, 1, 0, 0, 0, "lock_run");
      send(1, 8'h8E, 0, 1, 0, 0, 0, "lock_run");
      send(1, 8'h1C, 0, 1, 0, 0, 0, "lock_run");

      // Single-bit error, then unlock on four zero words, relock, idle gap
      do_reset();
      lock_seq("lock2");
      send(1, 8'h23, 0, 1, 0, 0, 0, "single_ok");
      send(1, 8'h46, 0, 1, 1, 1, 1, "single_err");
      send(1, 8'h8E, 0, 1, 0, 1, 1, "single_after");
      send(1, 8'h1C, 0, 1, 0, 1, 1, "single_after");
      send(1, 8'h00, 0, 1, 1,  4, 2, "unlock_miss1");
      send(1, 8'h00, 0, 1, 1,  8, 3, "unlock_miss2");
      send(1, 8'h00, 0, 1, 1, 12, 4, "unlock_miss3");
      send(1, 8'h00, 0, 0, 1, 15, 5, "unlock_miss4");
      send(1, 8'h89, 0, 0, 0, 15, 5, "rehunt");
      send(1, 8'h12, 0, 0, 0, 15, 5, "rehunt");
      send(1, 8'h25, 0, 0, 0, 15, 5, "rehunt");
      send(1, 8'h4B, 0, 0, 0, 15, 5, "rehunt");
      send(1, 8'h97, 0, 1, 0, 15, 5, "relock");
      for (int i = 0; i < 3; i++) send(0, 8'hFF, 0, 1, 0, 15, 5, "idle_gap");
      send(1, 8'h2E, 0, 1, 0, 15, 5, "after_gap");
      send(1, 8'h5C, 0, 1, 0, 15, 5, "after_gap");

      // Zero stream never locks
      do_reset();
      for (int i = 0; i < 20; i++) send(1, 8'h00, 0, 0, 0, 0, 0, "zero_stream");

      // Bit counter saturation, then clear beats a concurrent increment
      do_reset();
      lock_seq("lock3");
      send(1, 8'hDC, 0, 1, 1,  8, 1, "sat_bad1");
      send(1, 8'hB8, 0, 1, 1, 15, 2, "sat_bad2");
      send(1, 8'h71, 1, 1, 1,  0, 0, "clr_with_err");
      send(1, 8'h1C, 0, 1, 0,  0, 0, "after_clr");

      // Async reset mid-lock, between edges, while err_pulse is high
      do_reset();
      lock_seq("lock4");
      send(1, 8'h23, 0, 1, 0, 0, 0, "pre_rst");
      send(1, 8'h46, 0, 1, 1, 1, 1, "pre_rst_err");
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1 cmp("async_rst", 1'b0, 1'b0, 0, 0);
      release_rst();
      lock_seq("relock_after_rst");
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Sits directly downstream of the 8-bit PRBS generator (x^8+x^6+x^5+x^4+1, shift-left, feedback into bit 0).
- Consumes one 8-bit word per valid cycle, self-synchronises to the sequence, then free-runs its own prediction.
- Reports lock status, per-word error pulses and saturating bit/word error counters.
- Used for link and loopback BER checks.

Parameters:
- LOCK_COUNT, 4: consecutive correct successor words required to declare lock (>=1).
- UNLOCK_ERRS, 4: consecutive mismatched words while locked that force re-hunt (>=1).
- ERR_CNT_W, 16: width of both error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  8  received PRBS word.
- clr_cnt  in  1  synchronous clear of both error counters.
- locked  out  1  checker locked to sequence.
- err_pulse  out  1  one-cycle pulse, registered, for each mismatched word while locked.
- bit_err_cnt  out  ERR_CNT_W  saturating count of errored bits.
- word_err_cnt  out  ERR_CNT_W  saturating count of errored words.

Behaviour:
- Next-state function f(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}. All-zero is the lock-up state; 0x00 is never a valid seed.
- Reset (async assert, sync deassert internally): state=HUNT, locked=0, err_pulse=0, both counters=0, have_prev=0, match_run=0, miss_run=0.
- in_valid=0: all state holds; err_pulse=0.
- HUNT state, on valid:
  - If have_prev and in_data==f(prev) and in_data!=0, match_run++. Otherwise match_run=0.
  - prev<=in_data; have_prev<=1.
  - When the match reaches LOCK_COUNT: go to LOCKED, expected<=f(in_data), miss_run=0.
  - locked rises the cycle after that sample. No errors are counted in HUNT.
- LOCKED state, on valid:
  - Compare in_data against expected; expected<=f(expected) regardless of outcome, so errors do not propagate.
  - Mismatch: err_pulse=1 next cycle; word_err_cnt+=1; bit_err_cnt+=popcount(in_data^expected); miss_run++.
  - Match: miss_run=0.
  - When miss_run reaches UNLOCK_ERRS: go to HUNT, locked=0 next cycle, prev<=in_data, have_prev=1, match_run=0. Errors on that word are still counted.
- Counters saturate at all-ones and never wrap; the bit add is clamped.
- clr_cnt together with an increment: clear wins, counter=0 that cycle.
- clr_cnt does not affect lock state.
- Output latency: all outputs are registered, one cycle after the sampled input.
- rst_n asserted mid-lock: immediate return to reset values; a full re-hunt is required afterwards.

Decomposition:
- Package prbs_pkg:
  - function lfsr8_next (f above)
  - localparam tap mask 8'hB8
  - typedef enum logic {HUNT, LOCKED} chk_state_t
- Sub-module popcount8: combinational 8-bit to 4-bit popcount, instantiated once on the XOR word.
- Everything else is inline.

Test Plan:
- Lock: reset, feed 01,02,04,08,11,23,47,8E,1C (LOCK_COUNT=4) -> locked=1 the cycle after 0x11 is sampled; no err_pulse; counters stay 0.
- Single error: after lock, feed 23, 46 (instead of 47), 8E, 1C -> one err_pulse after 46; bit_err_cnt=1, word_err_cnt=1; 8E and 1C produce no error; locked stays 1.
- Unlock: after lock, feed 4 words of 00 -> word_err_cnt=4; locked=0 the cycle after the 4th; resume a correct sequence -> relocks after 4 further matches.
- Zero stream: 20 words of 0x00 from reset -> locked never asserts; counters 0.
- Saturation and clear (ERR_CNT_W=4): after lock, feed 2 words equal to ~expected -> bit_err_cnt=15 (saturated), word_err_cnt=2; then clr_cnt high during a third bad word -> both counters read 0 next cycle.
- Async reset and gaps: drop rst_n mid-lock between clock edges -> locked, err_pulse and counters go 0 immediately. Separately, while locked, insert 3 idle in_valid=0 cycles mid-sequence -> no errors; expected does not advance.
